// File: rtl/fpalu_add_sched.sv
// Round-robin scheduler sharing one fpalu_add among NREQ requesters.
// Operands are held on the adder for ADD_LAT cycles, then the sum is returned on a tagged response channel.
module fpalu_add_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int ADD_LAT = 2,
    parameter int CNTW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic [31:0]          add_sum,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 busy,
    output logic [CNTW-1:0]      ops_done
);
    localparam int WCW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_INIT = WCW'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_rsp_id;
    logic [IDW-1:0]  w_gnt;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;
    logic [31:0]     r_rsp_sum;
    logic [WCW-1:0]  r_wait_cnt;
    logic            r_rsp_valid;
    logic [CNTW-1:0] r_ops_done;
    logic            w_found;
    logic            w_handshake;
    logic            w_capture;
    logic            w_accept;
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_ready;
    logic [31:0]     w_sel_a;
    logic [31:0]     w_sel_b;

    // Rotating the valids by rr_ptr turns the round-robin search into a plain priority scan.
    assign w_rot = NREQ'({req_valid, req_valid} >> r_rr_ptr);

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_gnt   = IDW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(w_gnt) == k) begin
                w_ready[k] = w_found && (r_state == S_IDLE);
                w_sel_a    = req_a[32*k +: 32];
                w_sel_b    = req_b[32*k +: 32];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_handshake  = 1'b0;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_handshake  = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_ops_done  <= '0;
        end else begin
            if (w_handshake) begin
                r_op_a     <= w_sel_a;
                r_op_b     <= w_sel_b;
                r_rsp_id   <= w_gnt;
                r_rr_ptr   <= IDW'((int'(w_gnt) + 1) % NREQ);
                r_wait_cnt <= WAIT_INIT;
            end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (w_capture) begin
                r_rsp_sum   <= add_sum;
                r_rsp_valid <= 1'b1;
            end
            if (w_accept) begin
                r_rsp_valid <= 1'b0;
                r_ops_done  <= r_ops_done + 1'b1;
            end
        end
    end

    assign req_ready = w_ready;
    assign add_a     = r_op_a;
    assign add_b     = r_op_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign busy      = (r_state != S_IDLE);
    assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_fpalu_add_sched.sv
// Self-checking bench for fpalu_add_sched: vector table, directed corner sequences,
// and randomized traffic against a transaction-level model. The shared adder is a bench stand-in.
module tb_fpalu_add_sched;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int ADD_LAT = 2;
    localparam int CNTW    = 4;
    localparam int CMOD    = 1 << CNTW;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [31:0]         add_a;
    logic [31:0]         add_b;
    logic [31:0]         add_sum;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_sum;
    logic                busy;
    logic [CNTW-1:0]     ops_done;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;
    vec_t vecs [4];

    // Transaction-level model state for the random phase
    bit              mBusy;
    int              mId;
    int              mAge;
    int              mPtr;
    int              mOps;
    logic [31:0]     mA;
    logic [31:0]     mB;
    bit              expRsp;
    int              gnt;
    int              cand;
    logic [NREQ-1:0] rv;
    logic            rr;
    logic [NREQ-1:0] expReady;

    always #5 clk = ~clk;

    fpalu_add_sched #(
        .NREQ(NREQ), .IDW(IDW), .ADD_LAT(ADD_LAT), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .busy(busy), .ops_done(ops_done)
    );

    // Stand-in adder: known FP pairs give true IEEE sums, anything else a distinct pattern.
    function automatic logic [31:0] fakeAdd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'hC0000000 && b == 32'h3F800000) return 32'hBF800000;
        if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        return a + b;
    endfunction

    // One register stage: the sum is only correct once operands have been held ADD_LAT-1 edges.
    logic [31:0] addStage = '0;
    always @(posedge clk) addStage <= fakeAdd(add_a, add_b);
    assign add_sum = addStage;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
        req_valid = valid;
        rsp_ready = ready;
    endtask

    task automatic setOperands(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic resetDut();
        applyStimulus('0, 1'b0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // Single isolated request with rsp_ready high; ends back in IDLE at a falling edge.
    task automatic runSingle(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] sum, input int expOps);
        setOperands(id, a, b);
        applyStimulus(NREQ'(1) << id, 1'b1);
        #1 checkOutput("single_grant", 32'(req_ready), 32'(NREQ'(1) << id));
        tick(1);
        applyStimulus('0, 1'b1);
        checkOutput("single_busy", 32'(busy), 32'd1);
        checkOutput("single_add_a_t1", add_a, a);
        checkOutput("single_add_b_t1", add_b, b);
        checkOutput("single_rsp_early", 32'(rsp_valid), 32'd0);
        tick(1);
        checkOutput("single_rsp_early2", 32'(rsp_valid), 32'd0);
        checkOutput("single_add_a_t2", add_a, a);
        checkOutput("single_add_b_t2", add_b, b);
        tick(1);
        checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("single_rsp_id", 32'(rsp_id), 32'(id));
        checkOutput("single_rsp_sum", rsp_sum, sum);
        tick(1);
        checkOutput("single_rsp_drop", 32'(rsp_valid), 32'd0);
        checkOutput("single_idle", 32'(busy), 32'd0);
        checkOutput("single_ops", 32'(ops_done), 32'(expOps % CMOD));
    endtask

    initial begin
        vecs[0] = '{2, 32'h3F800000, 32'h40000000, 32'h40400000};
        vecs[1] = '{0, 32'hC0000000, 32'h3F800000, 32'hBF800000};
        vecs[2] = '{3, 32'h40000000, 32'h40000000, 32'h40800000};
        vecs[3] = '{1, 32'h12345678, 32'h11111111, 32'h23456789};

        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        applyStimulus('0, 1'b0);
        tick(2);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_rsp_sum", rsp_sum, 32'd0);
        checkOutput("rst_ops", 32'(ops_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_add_a", add_a, 32'd0);
        checkOutput("rst_add_b", add_b, 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 4; i++)
            runSingle(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, i + 1);

        $display("[TB] round-robin with all requesters valid");
        resetDut();
        for (int i = 0; i < NREQ; i++) setOperands(i, 32'h3F800000, 32'h40000000);
        applyStimulus('1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            #1 checkOutput($sformatf("rr_ready_c%0d", c), 32'(req_ready),
                           (c % 4 == 0) ? 32'(NREQ'(1) << ((c / 4) % NREQ)) : 32'd0);
            if (c % 4 == 3) begin
                checkOutput($sformatf("rr_rsp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
                checkOutput($sformatf("rr_rsp_id_c%0d", c), 32'(rsp_id), 32'((c / 4) % NREQ));
            end
            tick(1);
        end
        checkOutput("rr_ops", 32'(ops_done), 32'd5);

        $display("[TB] backpressure");
        resetDut();
        setOperands(0, 32'h40000000, 32'h40000000);
        setOperands(1, 32'h3F800000, 32'h40000000);
        applyStimulus(4'b0001, 1'b0);
        #1 checkOutput("bp_grant0", 32'(req_ready), 32'b0001);
        tick(1);
        applyStimulus(4'b0010, 1'b0);
        tick(2);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_id", 32'(rsp_id), 32'd0);
            checkOutput("bp_rsp_sum", rsp_sum, 32'h40800000);
            checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
            checkOutput("bp_ops_hold", 32'(ops_done), 32'd0);
            tick(1);
        end
        applyStimulus(4'b0010, 1'b1);
        tick(1);
        checkOutput("bp_release_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("bp_release_ops", 32'(ops_done), 32'd1);
        #1 checkOutput("bp_grant1", 32'(req_ready), 32'b0010);
        tick(1);
        applyStimulus('0, 1'b1);
        checkOutput("bp_add_a1", add_a, 32'h3F800000);
        tick(2);
        checkOutput("bp_rsp1_id", 32'(rsp_id), 32'd1);
        checkOutput("bp_rsp1_sum", rsp_sum, 32'h40400000);
        tick(1);
        checkOutput("bp_ops2", 32'(ops_done), 32'd2);

        $display("[TB] reset during WAIT");
        resetDut();
        runSingle(1, 32'h12345678, 32'h11111111, 32'h23456789, 1);
        setOperands(2, 32'h40000000, 32'h40000000);
        applyStimulus(4'b0100, 1'b1);
        tick(1);
        applyStimulus('0, 1'b1);
        checkOutput("mid_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("mid_rsp_sum", rsp_sum, 32'd0);
        checkOutput("mid_add_a", add_a, 32'd0);
        checkOutput("mid_add_b", add_b, 32'd0);
        checkOutput("mid_ops", 32'(ops_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runSingle(2, 32'h3F800000, 32'h40000000, 32'h40400000, 1);

        $display("[TB] skipping idle requesters");
        resetDut();
        setOperands(3, 32'hC0000000, 32'h3F800000);
        setOperands(0, 32'h3F800000, 32'h40000000);
        applyStimulus(4'b1000, 1'b1);
        #1 checkOutput("skip_grant3", 32'(req_ready), 32'b1000);
        tick(1);
        applyStimulus('0, 1'b1);
        tick(3);
        applyStimulus(4'b1001, 1'b1);
        #1 checkOutput("skip_ptr_wrap", 32'(req_ready), 32'b0001);
        tick(1);
        applyStimulus('0, 1'b1);
        tick(3);
        applyStimulus(4'b1001, 1'b1);
        #1 checkOutput("skip_ptr_next", 32'(req_ready), 32'b1000);
        tick(1);
        applyStimulus('0, 1'b1);
        tick(3);
        checkOutput("skip_ops", 32'(ops_done), 32'd3);

        $display("[TB] counter wrap");
        resetDut();
        for (int k = 0; k < 17; k++)
            runSingle(k % NREQ, 32'hC0000000, 32'h3F800000, 32'hBF800000, k + 1);

        $display("[TB] randomized traffic");
        resetDut();
        mBusy = 1'b0;
        mPtr  = 0;
        mOps  = 0;
        mAge  = 0;
        mId   = 0;
        mA    = '0;
        mB    = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            expRsp = mBusy && (mAge >= ADD_LAT);
            checkOutput("rnd_busy", 32'(busy), 32'(mBusy));
            checkOutput("rnd_rsp_valid", 32'(rsp_valid), 32'(expRsp));
            if (expRsp) begin
                checkOutput("rnd_rsp_id", 32'(rsp_id), 32'(mId));
                checkOutput("rnd_rsp_sum", rsp_sum, fakeAdd(mA, mB));
            end
            if (mBusy) begin
                checkOutput("rnd_add_a", add_a, mA);
                checkOutput("rnd_add_b", add_b, mB);
            end
            checkOutput("rnd_ops", 32'(ops_done), 32'(mOps % CMOD));

            rv = NREQ'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) setOperands(i, $urandom, $urandom);
            applyStimulus(rv, rr);

            gnt = -1;
            if (!mBusy) begin
                for (int k = 0; k < NREQ; k++) begin
                    cand = (mPtr + k) % NREQ;
                    if (gnt < 0 && rv[cand]) gnt = cand;
                end
            end
            expReady = (gnt >= 0) ? (NREQ'(1) << gnt) : '0;
            #1 checkOutput("rnd_ready", 32'(req_ready), 32'(expReady));

            if (gnt >= 0) begin
                mBusy = 1'b1;
                mId   = gnt;
                mA    = req_a[32*gnt +: 32];
                mB    = req_b[32*gnt +: 32];
                mPtr  = (gnt + 1) % NREQ;
                mAge  = 0;
            end else if (mBusy) begin
                if (expRsp && rr) begin
                    mBusy = 1'b0;
                    mOps++;
                end else begin
                    mAge++;
                end
            end
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
